// File: rtl/wfg_interconnect_pkg.sv
// Shared register map and field encodings for the interconnect page.
package wfg_interconnect_pkg;

    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_DRV_SEL  = 4'h4;
    localparam logic [3:0] REG_XFER_CNT = 4'h8;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam int         SEL_W            = 4;
    localparam logic [3:0] SEL_DISCONNECTED = 4'hF;

endpackage

// File: rtl/wfg_stream_router_wb.sv
// Wishbone slave and register file of the stream router: enable, per-driver
// source select, counter clear strobe and counter readback.
module wfg_stream_router_wb
    import wfg_interconnect_pkg::*;
#(
    parameter int DRIVERS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stb,
    input  logic                       cyc,
    input  logic                       we,
    input  logic [3:0]                 sel,
    input  logic [3:0]                 adr,
    input  logic [31:0]                dat_w,
    output logic                       ack,
    output logic [31:0]                dat_r,
    output logic                       en,
    output logic [DRIVERS*SEL_W-1:0]   drv_sel,
    output logic                       clr,
    input  logic [31:0]                xfer_cnt
);

    logic        req;
    logic [31:0] sel_reg;
    logic        sel_unused;

    // Byte lanes are not used: every access is a full word.
    assign sel_unused = &sel;

    // A new request is taken only while ack is low, so ack never stays high.
    assign req     = stb & cyc & ~ack;
    assign clr     = req & we & (adr == REG_CTRL) & dat_w[CTRL_CLR_BIT];
    assign drv_sel = sel_reg[DRIVERS*SEL_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            dat_r   <= '0;
            en      <= 1'b0;
            sel_reg <= {8{SEL_DISCONNECTED}};
        end else begin
            ack   <= req;
            dat_r <= '0;
            if (req && we) begin
                case (adr)
                    REG_CTRL:    en      <= dat_w[CTRL_EN_BIT];
                    REG_DRV_SEL: sel_reg <= dat_w;
                    default:     ;
                endcase
            end
            if (req && !we) begin
                case (adr)
                    REG_CTRL:     dat_r[CTRL_EN_BIT] <= en;
                    REG_DRV_SEL:  dat_r <= sel_reg;
                    REG_XFER_CNT: dat_r <= xfer_cnt;
                    default:      dat_r <= '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/wfg_stream_router.sv
// AXI-Stream crossbar: each driver picks one stimulus, a stimulus may feed
// several drivers, and every driver output is a one-entry register.
module wfg_stream_router
    import wfg_interconnect_pkg::*;
#(
    parameter int STIMULI = 2,
    parameter int DRIVERS = 2,
    parameter int DATAW   = 32
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [3:0]                 wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic [STIMULI-1:0]         stim_tvalid_i,
    input  logic [STIMULI*DATAW-1:0]   stim_tdata_i,
    output logic [STIMULI-1:0]         stim_tready_o,
    output logic [DRIVERS-1:0]         drv_tvalid_o,
    output logic [DRIVERS*DATAW-1:0]   drv_tdata_o,
    input  logic [DRIVERS-1:0]         drv_tready_i
);

    localparam int NCNT = (DRIVERS > 1) ? 2 : 1;

    logic                       en;
    logic                       clr;
    logic [DRIVERS*SEL_W-1:0]   drv_sel;
    logic [31:0]                xfer_cnt;
    logic [DRIVERS-1:0]         can_accept;
    logic [STIMULI-1:0]         has_sub;
    logic [DRIVERS-1:0]         load;
    logic [DATAW-1:0]           load_data [DRIVERS];
    logic [15:0]                cnt [NCNT];

    wfg_stream_router_wb #(.DRIVERS(DRIVERS)) u_wb (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .stb      (wbs_stb_i),
        .cyc      (wbs_cyc_i),
        .we       (wbs_we_i),
        .sel      (wbs_sel_i),
        .adr      (wbs_adr_i),
        .dat_w    (wbs_dat_i),
        .ack      (wbs_ack_o),
        .dat_r    (wbs_dat_o),
        .en       (en),
        .drv_sel  (drv_sel),
        .clr      (clr),
        .xfer_cnt (xfer_cnt)
    );

    // A stimulus is ready only if it has subscribers and all of them can take a beat.
    always_comb begin
        can_accept    = ~drv_tvalid_o | drv_tready_i;
        has_sub       = '0;
        stim_tready_o = {STIMULI{en}};
        for (int s = 0; s < STIMULI; s++) begin
            for (int d = 0; d < DRIVERS; d++) begin
                if (drv_sel[d*SEL_W +: SEL_W] == SEL_W'(s)) begin
                    has_sub[s] = 1'b1;
                    if (!can_accept[d]) stim_tready_o[s] = 1'b0;
                end
            end
        end
        stim_tready_o = stim_tready_o & has_sub;
    end

    always_comb begin
        load = '0;
        for (int d = 0; d < DRIVERS; d++) begin
            load_data[d] = '0;
            for (int s = 0; s < STIMULI; s++) begin
                if ((drv_sel[d*SEL_W +: SEL_W] == SEL_W'(s)) && stim_tvalid_i[s] && stim_tready_o[s]) begin
                    load[d]      = 1'b1;
                    load_data[d] = stim_tdata_i[s*DATAW +: DATAW];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            drv_tvalid_o <= '0;
            drv_tdata_o  <= '0;
        end else begin
            for (int d = 0; d < DRIVERS; d++) begin
                if (load[d]) begin
                    drv_tvalid_o[d]                  <= 1'b1;
                    drv_tdata_o[d*DATAW +: DATAW]    <= load_data[d];
                end else if (drv_tready_i[d]) begin
                    drv_tvalid_o[d] <= 1'b0;
                end
            end
        end
    end

    // Only the first two drivers are visible in XFER_CNT; clear wins over a completion.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (clr) cnt[i] <= '0;
                else if (drv_tvalid_o[i] && drv_tready_i[i]) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    if (NCNT > 1) begin : g_two_cnt
        assign xfer_cnt = {cnt[1], cnt[0]};
    end else begin : g_one_cnt
        assign xfer_cnt = {16'h0000, cnt[0]};
    end

endmodule

// File: tb/tb_wfg_stream_router.sv
// Randomized and directed bench for wfg_stream_router against a queue-based
// reference: each driver's register is modelled as a queue of pending beats.
module tb_wfg_stream_router;

    localparam int NSTIM = 2;
    localparam int NDRV  = 2;
    localparam int DW    = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  stb, cyc, we;
    logic [3:0]            sel;
    logic [3:0]            adr;
    logic [31:0]           dat_w;
    logic                  ack;
    logic [31:0]           dat_r;
    logic [NSTIM-1:0]      stim_tvalid;
    logic [NSTIM*DW-1:0]   stim_tdata;
    logic [NSTIM-1:0]      stim_tready;
    logic [NDRV-1:0]       drv_tvalid;
    logic [NDRV*DW-1:0]    drv_tdata;
    logic [NDRV-1:0]       drv_tready;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [DW-1:0] exp_q [NDRV][$];
    bit            m_en;
    logic [31:0]   m_sel;
    int            m_cnt [2];
    bit            m_ack;
    logic [31:0]   m_rdata;
    int            acc0;
    bit            rand_mode;

    always #5 clk = ~clk;

    wfg_stream_router #(.STIMULI(NSTIM), .DRIVERS(NDRV), .DATAW(DW)) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (dat_w),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat_r),
        .stim_tvalid_i (stim_tvalid),
        .stim_tdata_i  (stim_tdata),
        .stim_tready_o (stim_tready),
        .drv_tvalid_o  (drv_tvalid),
        .drv_tdata_o   (drv_tdata),
        .drv_tready_i  (drv_tready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDRV; d++) exp_q[d].delete();
        m_en     = 1'b0;
        m_sel    = 32'hFFFF_FFFF;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_ack    = 1'b0;
        m_rdata  = '0;
    endtask

    function automatic logic [NSTIM-1:0] model_ready();
        logic [NSTIM-1:0] r;
        bit sub, ok;
        for (int s = 0; s < NSTIM; s++) begin
            sub = 0;
            ok  = 1;
            for (int d = 0; d < NDRV; d++) begin
                if (m_sel[4*d +: 4] == s) begin
                    sub = 1;
                    if (exp_q[d].size() != 0 && !drv_tready[d]) ok = 0;
                end
            end
            r[s] = m_en & sub & ok;
        end
        return r;
    endfunction

    // One clock edge of the reference: reads see old state, config applies afterwards.
    task automatic model_update();
        bit req, clr;
        logic [31:0] rd;
        logic [NSTIM-1:0] rdy;
        bit [NDRV-1:0] comp;
        if (!rst_n) return;
        req = stb && cyc && !m_ack;
        rdy = model_ready();
        rd  = '0;
        if (req && !we) begin
            if (adr == 4'h0)      rd = {31'b0, m_en};
            else if (adr == 4'h4) rd = m_sel;
            else if (adr == 4'h8) rd = {16'(m_cnt[1]), 16'(m_cnt[0])};
        end
        for (int d = 0; d < NDRV; d++) begin
            comp[d] = (exp_q[d].size() != 0) && drv_tready[d];
            if (comp[d]) void'(exp_q[d].pop_front());
        end
        for (int s = 0; s < NSTIM; s++) begin
            if (stim_tvalid[s] && rdy[s]) begin
                for (int d = 0; d < NDRV; d++) begin
                    if (m_sel[4*d +: 4] == s) begin
                        exp_q[d].push_back(stim_tdata[s*DW +: DW]);
                        if (d == 0) acc0++;
                    end
                end
            end
        end
        clr = req && we && (adr == 4'h0) && dat_w[1];
        for (int d = 0; d < 2; d++) begin
            if (clr) m_cnt[d] = 0;
            else if (comp[d]) m_cnt[d] = (m_cnt[d] + 1) % 65536;
        end
        if (req && we) begin
            if (adr == 4'h0)      m_en  = dat_w[0];
            else if (adr == 4'h4) m_sel = dat_w;
        end
        m_ack   = req;
        m_rdata = rd;
    endtask

    task automatic check_all();
        chk("stim_tready", 32'(stim_tready), 32'(model_ready()));
        for (int d = 0; d < NDRV; d++) begin
            chk("drv_tvalid", 32'(drv_tvalid[d]), 32'(exp_q[d].size() != 0));
            if (exp_q[d].size() != 0) chk("drv_tdata", drv_tdata[d*DW +: DW], exp_q[d][0]);
        end
        chk("wb_ack", 32'(ack), 32'(m_ack));
        chk("wb_dat", dat_r, m_rdata);
    endtask

    task automatic drive_random();
        stim_tvalid = NSTIM'($urandom);
        stim_tdata  = {$urandom, $urandom};
        for (int d = 0; d < NDRV; d++) drv_tready[d] = ($urandom_range(0, 3) != 0);
    endtask

    // Inputs change at the negedge; outputs are checked just after, the model steps at posedge.
    task automatic tick();
        if (rand_mode) drive_random();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wb_xfer(input bit w, input logic [3:0] a, input logic [31:0] d,
                           output logic [31:0] rdat);
        stb   = 1'b1;
        cyc   = 1'b1;
        we    = w;
        adr   = a;
        dat_w = d;
        tick();
        rdat  = dat_r;
        stb   = 1'b0;
        cyc   = 1'b0;
        we    = 1'b0;
        tick();
    endtask

    logic [31:0] rd;
    logic [31:0] word;
    bit          prev_ack;
    int          nacks;

    initial begin
        rst_n       = 1'b0;
        stb         = 1'b0;
        cyc         = 1'b0;
        we          = 1'b0;
        sel         = 4'hF;
        adr         = '0;
        dat_w       = '0;
        stim_tvalid = '0;
        stim_tdata  = '0;
        drv_tready  = '1;
        rand_mode   = 1'b0;
        acc0        = 0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // register defaults and unmapped space
        wb_xfer(1'b0, 4'h4, 32'h0, rd);  chk("rst_drv_sel", rd, 32'hFFFF_FFFF);
        wb_xfer(1'b0, 4'h0, 32'h0, rd);  chk("rst_ctrl", rd, 32'h0);
        wb_xfer(1'b1, 4'hC, 32'h1234_5678, rd);
        wb_xfer(1'b0, 4'hC, 32'h0, rd);  chk("unmapped_rd", rd, 32'h0);

        // default route
        wb_xfer(1'b1, 4'h0, 32'h1, rd);
        wb_xfer(1'b1, 4'h4, 32'h10, rd);
        stim_tdata  = {32'h0000_0002, 32'hA5A5_0001};
        stim_tvalid = 2'b11;
        tick();
        stim_tvalid = 2'b00;
        #1;
        chk("route_d0", drv_tdata[31:0], 32'hA5A5_0001);
        chk("route_d1", drv_tdata[63:32], 32'h0000_0002);
        chk("route_vld", 32'(drv_tvalid), 32'h3);
        tick();
        wb_xfer(1'b0, 4'h8, 32'h0, rd);  chk("route_cnt", rd, 32'h0001_0001);

        // broadcast with backpressure on driver 1
        wb_xfer(1'b1, 4'h4, 32'h00, rd);
        drv_tready        = 2'b01;
        stim_tdata[31:0]  = 32'hB0B0_0001;
        stim_tvalid       = 2'b01;
        tick();
        stim_tdata[31:0]  = 32'hB0B0_0002;
        repeat (4) begin
            #1 chk("bcast_stall", 32'(stim_tready[0]), 32'h0);
            tick();
        end
        drv_tready = 2'b11;
        #1 chk("bcast_resume", 32'(stim_tready[0]), 32'h1);
        tick();
        stim_tvalid = 2'b00;
        repeat (3) tick();

        // disconnected, then disabled, then enabled
        wb_xfer(1'b1, 4'h4, 32'hFF, rd);
        stim_tvalid = 2'b01;
        repeat (10) begin
            #1;
            chk("disc_ready", 32'(stim_tready), 32'h0);
            chk("disc_vld", 32'(drv_tvalid), 32'h0);
            tick();
        end
        wb_xfer(1'b1, 4'h0, 32'h0, rd);
        wb_xfer(1'b1, 4'h4, 32'h10, rd);
        repeat (10) begin
            #1;
            chk("dis_ready", 32'(stim_tready), 32'h0);
            chk("dis_vld", 32'(drv_tvalid), 32'h0);
            tick();
        end
        wb_xfer(1'b1, 4'h0, 32'h1, rd);
        tick();
        #1 chk("en_flow", 32'(drv_tvalid[0]), 32'h1);
        stim_tvalid = 2'b00;
        repeat (2) tick();

        // drain on disable
        drv_tready       = 2'b10;
        stim_tdata[31:0] = 32'hD0D0_0001;
        stim_tvalid      = 2'b01;
        tick();
        stim_tdata[31:0] = 32'hD0D0_0002;
        wb_xfer(1'b1, 4'h0, 32'h0, rd);
        repeat (2) tick();
        #1;
        chk("drain_hold_vld", 32'(drv_tvalid[0]), 32'h1);
        chk("drain_hold_dat", drv_tdata[31:0], 32'hD0D0_0001);
        drv_tready = 2'b11;
        tick();
        #1;
        chk("drain_done", 32'(drv_tvalid[0]), 32'h0);
        chk("drain_no_accept", 32'(stim_tready[0]), 32'h0);
        stim_tvalid = 2'b00;
        tick();

        // counter wrap on driver 0
        wb_xfer(1'b1, 4'h4, 32'hF0, rd);
        wb_xfer(1'b1, 4'h0, 32'h3, rd);
        acc0        = 0;
        stim_tvalid = 2'b01;
        while (acc0 < 65536) begin
            stim_tdata[31:0] = $urandom;
            tick();
        end
        stim_tvalid = 2'b00;
        tick();
        wb_xfer(1'b0, 4'h8, 32'h0, rd);  chk("cnt_wrap", 32'(rd[15:0]), 32'h0);

        // clear coinciding with a completion
        stim_tvalid = 2'b01;
        repeat (5) tick();
        drv_tready  = 2'b10;
        tick();
        stim_tvalid = 2'b00;
        tick();
        drv_tready  = 2'b11;
        wb_xfer(1'b1, 4'h0, 32'h3, rd);
        wb_xfer(1'b0, 4'h8, 32'h0, rd);  chk("cnt_clr", 32'(rd[15:0]), 32'h0);

        // back-to-back strobes
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 4'h4;
        prev_ack = 1'b0;
        nacks    = 0;
        repeat (8) begin
            tick();
            chk("ack_single", 32'(ack & prev_ack), 32'h0);
            prev_ack = ack;
            if (ack) nacks++;
        end
        stb = 1'b0; cyc = 1'b0;
        tick();
        chk("ack_pulses", 32'(nacks), 32'd4);

        // randomized traffic with reconfiguration
        rand_mode = 1'b1;
        wb_xfer(1'b1, 4'h0, 32'h1, rd);
        for (int r = 0; r < 12; r++) begin
            word = 32'hFFFF_FFFF;
            for (int d = 0; d < NDRV; d++) begin
                int v;
                v = $urandom_range(0, 2);
                word[4*d +: 4] = (v == 2) ? 4'hF : 4'(v);
            end
            wb_xfer(1'b1, 4'h4, word, rd);
            if (r == 5) wb_xfer(1'b1, 4'h0, 32'h0, rd);
            if (r == 7) wb_xfer(1'b1, 4'h0, 32'h1, rd);
            repeat (150) tick();
            wb_xfer(1'b0, 4'h8, 32'h0, rd);
        end

        // asynchronous reset in the middle of traffic
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 32'(stim_tready), 32'h0);
        chk("rst_async_vld", 32'(drv_tvalid), 32'h0);
        chk("rst_async_dat", drv_tdata[31:0] | drv_tdata[63:32], 32'h0);
        chk("rst_async_ack", 32'(ack), 32'h0);
        chk("rst_async_wbdat", dat_r, 32'h0);
        model_reset();
        repeat (2) tick();
        rand_mode   = 1'b0;
        stim_tvalid = '0;
        drv_tready  = '1;
        tick();
        rst_n = 1'b1;
        tick();
        wb_xfer(1'b0, 4'h4, 32'h0, rd);  chk("post_rst_drv_sel", rd, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
